master_spictrl_gen: RTL and testbench
=====================================

# master_spictrl_gen

Parametrised SPI master controller and the next-generation replacement for the fixed 16-bit, single-chip-select SPI master in the Post machine peripheral set. It adds a configurable word width, several chip selects, and all four SPI modes (CPOL/CPHA) selected at run time. SCK rate comes from a run-time divisor implemented as a clock-enable, so the block needs no derived or multiplexed clock. It sits between the Post machine I/O registers and external SPI slaves; one `GO` edge produces one full-duplex, MSB-first word transfer.

## Interface
- `WIDTH`, 16: bits per transfer (≥2).
- `NCS`, 4: number of chip-select lines (≥1).
- `DIV_W`, 8: width of the `DIV` divisor input.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `GO` in 1: start request; only a rising edge starts a transfer.
- `TX_W` in WIDTH: word to transmit.
- `CS_SEL` in max(1,clog2(NCS)): index of the chip select to assert.
- `CPOL` in 1: SCK idle level.
- `CPHA` in 1: SCK phase (0 = sample on the first edge, 1 = sample on the second edge).
- `DIV` in DIV_W: SCK half-period is DIV+1 CLK cycles.
- `MISO` in 1: serial data from the slave.
- `CS` out NCS: chip selects, active-low.
- `SCK` out 1: serial clock.
- `MOSI` out 1: serial data to the slave.
- `RX_W` out WIDTH: last received word.
- `BUSY` out 1: transfer in progress.
- `DONE` out 1: one-cycle pulse when `RX_W` is updated.

## Operation
- **Reset values:** `CS` all 1; `SCK`=0; `MOSI`=0; `RX_W`=0; `BUSY`=0; `DONE`=0; state IDLE; `go_d`=0.
- **Start detection:** `go_d` registers `GO`. `start = GO & ~go_d & (state==IDLE)`.
  - Edges while not IDLE are dropped, not queued.
  - `GO` held high gives exactly one transfer.
- **Latching on start:** `TX_W`, `CS_SEL`, `CPOL`, `CPHA` and `DIV` are latched. Input changes during BUSY have no effect.
- **Tick generator:** a half-period counter reloads to `DIV` on start and on every tick. It counts down only while not IDLE, and `tick` fires when it reaches 0.
- **IDLE:**
  - `SCK` follows the registered live `CPOL`.
  - `MOSI`=0 and `CS` all 1.
  - On start, go to SETUP.
- **SETUP** (one half-period):
  - Selected `CS` bit is low; `MOSI` = latched MSB.
  - On tick, go to SHIFT with `edge_cnt`=0.
- **SHIFT** (2·WIDTH half-periods): on each tick, `SCK` toggles and `edge_cnt` increments. Edge number k (1-based) behaves as follows.
  - **CPHA=0:** sample `MISO` into the shift register on odd k; shift out the next `MOSI` bit on even k, except the final edge.
  - **CPHA=1:** shift out on odd k (edge 1 presents the MSB); sample on even k.
  - After edge 2·WIDTH, `SCK` is back at `CPOL`; go to HOLD.
- **HOLD** (one half-period):
  - `CS` stays asserted and `SCK` stays at `CPOL`.
  - On tick, go to IDLE. In that same cycle, `CS` goes all 1, `RX_W` is loaded from the shift register, and `DONE`=1.
- **Chip-select range:** if `CS_SEL` ≥ NCS, no `CS` bit asserts, but the transfer still runs and `RX_W`/`DONE` update normally.
- **Reset mid-transfer:** all outputs go to reset values immediately, and any partial word is discarded.

## Timing
- `GO` rises in cycle t. In cycle t+1, `BUSY`=1, `CS` is asserted and `MOSI` holds the MSB (CPHA=0).
- `BUSY` stays high for exactly (2·WIDTH+2)·(DIV+1) cycles. `DONE` is high in the first cycle with `BUSY`=0.
- A new `GO` edge is accepted in the cycle after `DONE`. Minimum idle gap between transfers is 1 cycle.
- f_SCK = f_CLK / (2·(DIV+1)). DIV=0 gives CLK/2.
- `SCK`, `MOSI` and `CS` are registered outputs with no combinational path from the inputs.
- `MISO` is sampled in the CLK cycle of the sampling tick. There is no input synchroniser; the board must meet setup at CLK.

## Structure
- **Shared package `spi_gen_pkg`:**
  - State encoding: IDLE, SETUP, SHIFT, HOLD.
  - Mode constants: MODE0–MODE3 as {CPOL,CPHA}.
  - A clog2-based width helper for `CS_SEL`.
- **Sub-module `spi_sck_timer`:** parametrised by DIV_W. It holds the half-period down-counter with load/enable and produces `tick`. Everything else is in the top-level FSM and datapath.

## Test plan
- **Mode 0 loopback:** WIDTH=16, DIV=0, CPOL=0, CPHA=0, `MISO` looped to `MOSI`, `TX_W`=16'hA5C3. Required: `RX_W`=16'hA5C3; `BUSY` high 34 cycles; 16 SCK rising edges; `DONE` one cycle.
- **Mode 3 slave model:** DIV=3, CPOL=1, CPHA=1, slave returns 16'h1234, `TX_W`=16'hF00F. Required: slave captures 16'hF00F; `RX_W`=16'h1234; SCK period 8 cycles; SCK idles high; `BUSY` 136 cycles.
- **Chip-select decode:** NCS=4, `CS_SEL`=2 gives `CS`=4'b1011 during the transfer and 4'b1111 after it. With NCS=3 and `CS_SEL`=3, `CS` stays 3'b111 and `DONE` still pulses.
- **Busy rules:** `GO` toggled mid-transfer and `TX_W` changed mid-transfer. Required: exactly one transfer; transmitted word equals the value latched at start. `GO` held high for 200 cycles gives a single `DONE`.
- **Reset mid-transfer:** `RST` asserted at edge 7 of 16. Required: `CS`=all 1, `SCK`=0, `BUSY`=0 in the same cycle; `RX_W`=0; a following `GO` completes normally.
- **Width generality:** WIDTH=8, DIV=1, mode 1, `TX_W`=8'h81 with loopback. Required: `RX_W`=8'h81; `BUSY`=(16+2)·2=36 cycles.

Source files
------------

// File: rtl/spi_gen_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_t;

   // SPI modes encoded as {CPOL, CPHA}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Width of the chip-select index; a single chip select still needs one bit.
   function automatic int cs_sel_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_sck_timer.sv
// SCK half-period timer: down-counter that fires a one-cycle tick at zero
// and reloads with the supplied divisor on load or on its own tick.
module spi_sck_timer #(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == '0);

   // Half-period down-counter with reload on start and on every tick
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load || o_tick) begin
         r_cnt <= i_div;
      end else if (i_en) begin
         r_cnt <= r_cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/master_spictrl_gen.sv
// SPI master: one GO rising edge runs one full-duplex MSB-first transfer
// in any of the four CPOL/CPHA modes, with SCK derived from a clock enable.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no transfer; SCK follows live CPOL, CS all high, MOSI low
// ST_SETUP | CS asserted, MSB on MOSI, one half-period before SHIFT
// ST_SHIFT | 2*WIDTH SCK edges; sample/shift according to latched CPHA
// ST_HOLD  | one half-period with CS held, then RX_W/DONE update
module master_spictrl_gen
   import spi_gen_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NCS   = 4,
   parameter int DIV_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_go,
   input  logic [WIDTH-1:0]         i_tx_w,
   input  logic [cs_sel_w(NCS)-1:0] i_cs_sel,
   input  logic                     i_cpol,
   input  logic                     i_cpha,
   input  logic [DIV_W-1:0]         i_div,
   input  logic                     i_miso,
   output logic [NCS-1:0]           o_cs,
   output logic                     o_sck,
   output logic                     o_mosi,
   output logic [WIDTH-1:0]         o_rx_w,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam int CSW = cs_sel_w(NCS);
   localparam int ECW = $clog2(2 * WIDTH + 1);

   spi_state_t       r_state;
   logic             r_go_d;
   logic [WIDTH-1:0] r_sh;
   logic [ECW-1:0]   r_edge_cnt;
   logic             r_cpol;
   logic             r_cpha;
   logic [DIV_W-1:0] r_div;
   logic [NCS-1:0]   r_cs;
   logic             r_sck;
   logic             r_mosi;
   logic [WIDTH-1:0] r_rx;
   logic             r_busy;
   logic             r_done;

   logic             w_start;
   logic             w_tick;
   logic             w_last;
   logic             w_sample;
   logic             w_shift_out;
   logic [DIV_W-1:0] w_div_load;
   logic [NCS-1:0]   w_cs_dec;

   assign w_start    = i_go & ~r_go_d & (r_state == ST_IDLE);
   // The start reload must use the live divisor; later reloads use the latched one.
   assign w_div_load = w_start ? i_div : r_div;
   assign w_last     = (r_edge_cnt == ECW'(2 * WIDTH - 1));
   // Edge number k = r_edge_cnt+1 is odd when r_edge_cnt is even.
   // CPHA=0 samples on odd edges, CPHA=1 on even edges.
   assign w_sample    = ~r_edge_cnt[0] ^ r_cpha;
   assign w_shift_out = ~w_sample & ~w_last;

   // One-hot active-low chip-select decode; out-of-range index selects nothing
   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < NCS; i++) begin
         if (i_cs_sel == CSW'(i)) begin
            w_cs_dec[i] = 1'b0;
         end
      end
   end

   spi_sck_timer #(
      .DIV_W (DIV_W)
   ) u_sck_timer (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_start),
      .i_en   (r_state != ST_IDLE),
      .i_div  (w_div_load),
      .o_tick (w_tick)
   );

   // Transfer FSM with registered SPI pins, shift register and status
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_go_d     <= 1'b0;
         r_sh       <= '0;
         r_edge_cnt <= '0;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_div      <= '0;
         r_cs       <= '1;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b0;
         r_rx       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_go_d <= i_go;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_sck  <= i_cpol;
               r_mosi <= 1'b0;
               r_cs   <= '1;
               if (w_start) begin
                  r_state    <= ST_SETUP;
                  r_busy     <= 1'b1;
                  r_sh       <= i_tx_w;
                  r_mosi     <= i_tx_w[WIDTH-1];
                  r_cs       <= w_cs_dec;
                  r_cpol     <= i_cpol;
                  r_cpha     <= i_cpha;
                  r_div      <= i_div;
                  r_edge_cnt <= '0;
               end
            end
            ST_SETUP: begin
               if (w_tick) begin
                  r_state    <= ST_SHIFT;
                  r_edge_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  r_sck      <= ~r_sck;
                  r_edge_cnt <= r_edge_cnt + ECW'(1);
                  // Sampling shifts MISO in from the bottom; the bit that
                  // reaches the top is the next one to drive on MOSI.
                  if (w_sample) begin
                     r_sh <= {r_sh[WIDTH-2:0], i_miso};
                  end
                  if (w_shift_out) begin
                     r_mosi <= r_sh[WIDTH-1];
                  end
                  if (w_last) begin
                     r_state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (w_tick) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cs    <= '1;
                  r_mosi  <= 1'b0;
                  r_sck   <= r_cpol;
                  r_rx    <= r_sh;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_cs   = r_cs;
   assign o_sck  = r_sck;
   assign o_mosi = r_mosi;
   assign o_rx_w = r_rx;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_master_spictrl_gen.sv
// Bench for master_spictrl_gen: a 16-bit/4-CS instance and an 8-bit/3-CS
// instance; expected transfer results are queued at stimulus time and
// checked by per-instance monitors whenever DONE pulses.
`timescale 1ns/1ps
module tb_master_spictrl_gen;
   import spi_gen_pkg::*;

   logic        clk;
   logic        rst;

   logic        go0, cpol0, cpha0, miso0, loop0;
   logic [15:0] tx0, rx0;
   logic [1:0]  sel0;
   logic [7:0]  div0;
   logic [3:0]  cs0;
   logic        sck0, mosi0, busy0, done0;

   logic        go1, cpol1, cpha1, miso1;
   logic [7:0]  tx1, rx1;
   logic [1:0]  sel1;
   logic [7:0]  div1;
   logic [2:0]  cs1;
   logic        sck1, mosi1, busy1, done1;

   logic        slv_en, slv_miso;
   logic [15:0] slv_tx, slv_rx;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int bc0 = 0, bc1 = 0, rises0 = 0, per0 = 0, last_rise0 = 0;
   logic [3:0] csa0 = '1, cso0 = '0;
   logic [2:0] csa1 = '1, cso1 = '0;

   typedef struct {
      logic [15:0] rx;
      int          busy;
      logic [3:0]  cs;
      int          rises;
      int          period;
      logic        chk_slave;
      logic [15:0] slave;
   } exp0_t;

   typedef struct {
      logic [7:0] rx;
      int         busy;
      logic [2:0] cs;
   } exp1_t;

   exp0_t q0[$];
   exp1_t q1[$];
   exp0_t e0;
   exp1_t e1;

   assign miso0 = loop0 ? mosi0 : slv_miso;
   assign miso1 = mosi1;

   master_spictrl_gen #(.WIDTH(16), .NCS(4), .DIV_W(8)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_go(go0), .i_tx_w(tx0), .i_cs_sel(sel0),
      .i_cpol(cpol0), .i_cpha(cpha0), .i_div(div0), .i_miso(miso0),
      .o_cs(cs0), .o_sck(sck0), .o_mosi(mosi0), .o_rx_w(rx0),
      .o_busy(busy0), .o_done(done0)
   );

   master_spictrl_gen #(.WIDTH(8), .NCS(3), .DIV_W(8)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_go(go1), .i_tx_w(tx1), .i_cs_sel(sel1),
      .i_cpol(cpol1), .i_cpha(cpha1), .i_div(div1), .i_miso(miso1),
      .o_cs(cs1), .o_sck(sck1), .o_mosi(mosi1), .o_rx_w(rx1),
      .o_busy(busy1), .o_done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Mode-3 slave: drives MISO on falling SCK, captures MOSI on rising SCK
   always @(negedge sck0) begin
      if (slv_en && busy0) begin
         slv_miso = slv_tx[15];
         slv_tx   = {slv_tx[14:0], 1'b0};
      end
   end

   always @(posedge sck0) begin
      if (busy0) begin
         rises0++;
         per0       = cyc - last_rise0;
         last_rise0 = cyc;
         if (slv_en) slv_rx = {slv_rx[14:0], mosi0};
      end
   end

   // Monitor for the 16-bit instance
   always @(negedge clk) begin
      if (rst) begin
         bc0 = 0; csa0 = '1; cso0 = '0; rises0 = 0;
      end else begin
         if (busy0) begin
            bc0++; csa0 &= cs0; cso0 |= cs0;
         end
         if (done0) begin
            n_chk++;
            if (q0.size() == 0) begin
               $display("FAIL dut0_unexpected_done: rx=%0h with no transfer pending", rx0);
            end else begin
               n_pass++;
               e0 = q0.pop_front();
               check("dut0_rx", rx0, e0.rx);
               check("dut0_busy_cycles", bc0, e0.busy);
               check("dut0_cs_during", {cso0, csa0}, {e0.cs, e0.cs});
               check("dut0_cs_after", cs0, 4'hF);
               check("dut0_sck_rises", rises0, e0.rises);
               check("dut0_sck_period", per0, e0.period);
               if (e0.chk_slave) check("dut0_slave_rx", slv_rx, e0.slave);
            end
            bc0 = 0; csa0 = '1; cso0 = '0; rises0 = 0;
         end
      end
   end

   // Monitor for the 8-bit instance
   always @(negedge clk) begin
      if (rst) begin
         bc1 = 0; csa1 = '1; cso1 = '0;
      end else begin
         if (busy1) begin
            bc1++; csa1 &= cs1; cso1 |= cs1;
         end
         if (done1) begin
            n_chk++;
            if (q1.size() == 0) begin
               $display("FAIL dut1_unexpected_done: rx=%0h with no transfer pending", rx1);
            end else begin
               n_pass++;
               e1 = q1.pop_front();
               check("dut1_rx", rx1, e1.rx);
               check("dut1_busy_cycles", bc1, e1.busy);
               check("dut1_cs_during", {cso1, csa1}, {e1.cs, e1.cs});
               check("dut1_cs_after", cs1, 3'b111);
            end
            bc1 = 0; csa1 = '1; cso1 = '0;
         end
      end
   end

   task automatic xfer0(input logic [15:0] tx, input logic [1:0] sel,
                        input logic [1:0] mode, input logic [7:0] div);
      @(posedge clk); #1;
      tx0 = tx; sel0 = sel; {cpol0, cpha0} = mode; div0 = div; go0 = 1'b1;
      @(posedge clk); #1;
      go0 = 1'b0;
   endtask

   task automatic xfer1(input logic [7:0] tx, input logic [1:0] sel,
                        input logic [1:0] mode, input logic [7:0] div);
      @(posedge clk); #1;
      tx1 = tx; sel1 = sel; {cpol1, cpha1} = mode; div1 = div; go1 = 1'b1;
      @(posedge clk); #1;
      go1 = 1'b0;
   endtask

   task automatic wait_done0(input int bound);
      int n;
      n = 0;
      while (done0 !== 1'b1 && n < bound) begin
         @(negedge clk); n++;
      end
      check("dut0_done_seen", done0, 1);
   endtask

   task automatic wait_done1(input int bound);
      int n;
      n = 0;
      while (done1 !== 1'b1 && n < bound) begin
         @(negedge clk); n++;
      end
      check("dut1_done_seen", done1, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      go0 = 0; tx0 = '0; sel0 = '0; cpol0 = 0; cpha0 = 0; div0 = '0; loop0 = 1'b1;
      go1 = 0; tx1 = '0; sel1 = '0; cpol1 = 0; cpha1 = 0; div1 = '0;
      slv_en = 0; slv_tx = '0; slv_rx = '0; slv_miso = 0;

      repeat (3) @(negedge clk);
      check("reset_cs0", cs0, 4'hF);
      check("reset_sck0", sck0, 0);
      check("reset_mosi0", mosi0, 0);
      check("reset_rx0", rx0, 0);
      check("reset_busy0", busy0, 0);
      check("reset_done0", done0, 0);
      check("reset_cs1", cs1, 3'b111);
      rst = 1'b0;

      // Mode 0 loopback, DIV=0, with start-latency checks
      q0.push_back('{16'hA5C3, 34, 4'b1110, 16, 2, 1'b0, 16'h0});
      xfer0(16'hA5C3, 2'd0, MODE0, 8'd0);
      @(negedge clk);
      check("t1_busy_high", busy0, 1);
      check("t1_cs_asserted", cs0, 4'b1110);
      check("t1_mosi_msb", mosi0, 1);
      wait_done0(100);

      // Mode 3 against the slave model, DIV=3
      @(posedge clk); #1;
      cpol0 = 1'b1; cpha0 = 1'b1;
      repeat (2) @(posedge clk); #1;
      loop0 = 1'b0; slv_en = 1'b1; slv_tx = 16'h1234; slv_rx = '0;
      q0.push_back('{16'h1234, 136, 4'b1110, 16, 8, 1'b1, 16'hF00F});
      xfer0(16'hF00F, 2'd0, MODE3, 8'd3);
      wait_done0(300);
      repeat (2) @(negedge clk);
      check("t2_sck_idle_high", sck0, 1);
      slv_en = 1'b0; loop0 = 1'b1;

      // Chip-select decode, index 2
      q0.push_back('{16'h5A5A, 68, 4'b1011, 16, 4, 1'b0, 16'h0});
      xfer0(16'h5A5A, 2'd2, MODE0, 8'd1);
      wait_done0(200);

      // GO toggled and inputs changed mid-transfer
      q0.push_back('{16'h1111, 34, 4'b1110, 16, 2, 1'b0, 16'h0});
      xfer0(16'h1111, 2'd0, MODE0, 8'd0);
      repeat (5) @(posedge clk); #1;
      tx0 = 16'hFFFF; go0 = 1'b1;
      @(posedge clk); #1; go0 = 1'b0;
      @(posedge clk); #1; go0 = 1'b1; div0 = 8'd7; cpha0 = 1'b1;
      @(posedge clk); #1; go0 = 1'b0;
      wait_done0(100);
      repeat (40) @(negedge clk);
      check("t4_idle_after", busy0, 0);

      // GO held high for 200 cycles
      q0.push_back('{16'h3C3C, 34, 4'b1110, 16, 2, 1'b0, 16'h0});
      @(posedge clk); #1;
      tx0 = 16'h3C3C; sel0 = 2'd0; {cpol0, cpha0} = MODE0; div0 = 8'd0; go0 = 1'b1;
      repeat (200) @(posedge clk); #1;
      go0 = 1'b0;
      check("t5_busy_after_held_go", busy0, 0);
      check("t5_rx_held_go", rx0, 16'h3C3C);

      // Reset right after SCK edge 7
      xfer0(16'hFFFF, 2'd0, MODE0, 8'd0);
      n = 0;
      while (rises0 < 4 && n < 50) begin
         @(negedge clk); n++;
      end
      check("t6_reached_edge7", rises0, 4);
      rst = 1'b1;
      #1;
      check("t6_rst_cs", cs0, 4'hF);
      check("t6_rst_sck", sck0, 0);
      check("t6_rst_busy", busy0, 0);
      check("t6_rst_rx", rx0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q0.push_back('{16'h0F0F, 34, 4'b1101, 16, 2, 1'b0, 16'h0});
      xfer0(16'h0F0F, 2'd1, MODE0, 8'd0);
      wait_done0(100);

      // 8-bit instance: mode 1 loopback DIV=1, then out-of-range CS
      q1.push_back('{8'h81, 36, 3'b110});
      xfer1(8'h81, 2'd0, MODE1, 8'd1);
      wait_done1(100);
      q1.push_back('{8'h3C, 18, 3'b111});
      xfer1(8'h3C, 2'd3, MODE0, 8'd0);
      wait_done1(100);

      repeat (5) @(negedge clk);
      check("dut0_queue_empty", q0.size(), 0);
      check("dut1_queue_empty", q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
